// File: rtl/or3_wake_filter.sv
// or3_wake_filter: synchronizes three async wake requests, debounces their OR
// and holds a sticky wake flag plus source mask until acknowledged.
module or3_wake_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4
) (
`ifdef USE_POWER_PINS
    inout  wire        VDD,
    inout  wire        VSS,
`endif
    input  logic       CLK,
    input  logic       RST,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       EN,
    input  logic       ACK,
    output logic       Z,
    output logic [2:0] SRC
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILTER, S_ASSERT, S_RELEASE} state_t;

    logic [2:0]    r_sync [SYNC_STAGES];
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_z, w_z_nxt, w_any;
    logic [2:0]    r_src, w_src_nxt, w_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= {A3, A2, A1};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_any     = EN & (|w_s);
    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_z     <= 1'b0;
            r_src   <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_z     <= w_z_nxt;
            r_src   <= w_src_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_z_nxt     = r_z;
        w_src_nxt   = r_src;
        case (r_state)
            S_IDLE: begin
                w_z_nxt   = 1'b0;
                w_src_nxt = 3'b000;
                w_cnt_nxt = '0;
                if (w_any && DEB_CYCLES == 1) begin
                    w_state_nxt = S_ASSERT;
                    w_cnt_nxt   = CW'(DEB_CYCLES);
                    w_z_nxt     = 1'b1;
                    w_src_nxt   = w_s;
                end else if (w_any) begin
                    w_state_nxt = S_FILTER;
                    w_cnt_nxt   = CW'(1);
                end
            end
            S_FILTER: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CW'(DEB_CYCLES)) begin
                        w_state_nxt = S_ASSERT;
                        w_z_nxt     = 1'b1;
                        w_src_nxt   = w_s;
                    end
                end
            end
            S_ASSERT: begin
                // ACK beats a same-cycle new source; that source must requalify
                if (ACK) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_z_nxt     = 1'b0;
                    w_src_nxt   = 3'b000;
                end else begin
                    w_src_nxt = r_src | w_s;
                end
            end
            S_RELEASE: begin
                // wait for the held level to drop so it cannot retrigger
                w_state_nxt = w_any ? S_RELEASE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign Z   = r_z;
    assign SRC = r_src;
endmodule

// File: tb/tb_or3_wake_filter.sv
// tb_or3_wake_filter: directed + random stimulus, run-length reference model,
// scoreboard queue drained by an independent monitor.
module tb_or3_wake_filter;
    localparam int SS = 2;
    localparam int DB = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       A1 = 1'b0, A2 = 1'b0, A3 = 1'b0, EN = 1'b1, ACK = 1'b0;
    logic       Z;
    logic [2:0] SRC;

    typedef struct packed {
        logic       z;
        logic [2:0] src;
    } exp_t;

    exp_t       sb[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [2:0] hist[$];
    int         run;
    logic       m_wake, m_armed;
    logic [2:0] m_mask;

    or3_wake_filter #(.SYNC_STAGES(SS), .DEB_CYCLES(DB)) dut (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .A3(A3),
        .EN(EN), .ACK(ACK), .Z(Z), .SRC(SRC)
    );

    always #5 CLK = ~CLK;

    // Model in terms of a delayed input history and a qualified run length.
    function automatic void model_edge(input logic [2:0] a, input logic en, input logic ack,
                                       input logic rst);
        logic [2:0] s;
        logic       any;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < SS; i++) hist.push_back(3'b000);
            run = 0; m_wake = 1'b0; m_mask = 3'b000; m_armed = 1'b1;
            return;
        end
        s = hist.pop_front();
        hist.push_back(a);
        any = en && (s != 3'b000);
        if (m_wake) begin
            if (ack) begin
                m_wake = 1'b0; m_mask = 3'b000; m_armed = 1'b0; run = 0;
            end else begin
                m_mask = m_mask | s;
            end
        end else if (!m_armed) begin
            if (!any) m_armed = 1'b1;
        end else begin
            run = any ? run + 1 : 0;
            if (run >= DB) begin
                m_wake = 1'b1; m_mask = s; run = 0;
            end
        end
    endfunction

    task automatic cyc(input logic [2:0] a, input logic en, input logic ack, input logic rst,
                       input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            {A3, A2, A1} = a; EN = en; ACK = ack; RST = rst;
            model_edge(a, en, ack, rst);
            sb.push_back('{z: m_wake, src: m_mask});
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_chk++;
                if (Z !== e.z) begin
                    n_fail++;
                    $display("FAIL z at %0t: got %b expected %b", $time, Z, e.z);
                end
                n_chk++;
                if (SRC !== e.src) begin
                    n_fail++;
                    $display("FAIL src at %0t: got %b expected %b", $time, SRC, e.src);
                end
            end
        end
    end

    initial begin : stim
        for (int i = 0; i < SS; i++) hist.push_back(3'b000);
        run = 0; m_wake = 1'b0; m_mask = 3'b000; m_armed = 1'b1;
        // reset with A2 held, then release
        cyc(3'b010, 1, 0, 1, 2);
        cyc(3'b010, 1, 0, 0, 8);
        cyc(3'b000, 1, 1, 0, 1);
        cyc(3'b000, 1, 0, 0, 4);
        // short glitch rejected
        cyc(3'b010, 1, 0, 0, 3);
        cyc(3'b000, 1, 0, 0, 6);
        // A1 wake, A3 accumulates, ACK, held level, requalify
        cyc(3'b001, 1, 0, 0, 7);
        cyc(3'b101, 1, 0, 0, 4);
        cyc(3'b101, 1, 1, 0, 1);
        cyc(3'b001, 1, 0, 0, 6);
        cyc(3'b000, 1, 0, 0, 2);
        cyc(3'b001, 1, 0, 0, 8);
        cyc(3'b001, 1, 1, 0, 1);
        cyc(3'b000, 1, 0, 0, 3);
        // one-cycle dropout during counting restarts the count
        cyc(3'b010, 1, 0, 0, 4);
        cyc(3'b000, 1, 0, 0, 1);
        cyc(3'b010, 1, 0, 0, 8);
        cyc(3'b010, 1, 1, 0, 1);
        cyc(3'b000, 1, 0, 0, 3);
        // EN masking, and EN=0 not dropping a pending wake
        cyc(3'b100, 0, 0, 0, 10);
        cyc(3'b100, 1, 0, 0, 7);
        cyc(3'b100, 0, 0, 0, 5);
        cyc(3'b100, 0, 1, 0, 1);
        cyc(3'b000, 1, 0, 0, 3);
        // reset mid-filter, then reset in assert with ACK
        cyc(3'b001, 1, 0, 0, 4);
        cyc(3'b001, 1, 0, 1, 1);
        cyc(3'b000, 1, 0, 0, 6);
        cyc(3'b011, 1, 0, 0, 8);
        cyc(3'b011, 1, 1, 1, 1);
        cyc(3'b000, 1, 0, 0, 6);
        // ACK together with a new source
        cyc(3'b001, 1, 0, 0, 7);
        cyc(3'b011, 1, 0, 0, 2);
        cyc(3'b111, 1, 1, 0, 1);
        cyc(3'b110, 1, 0, 0, 4);
        cyc(3'b000, 1, 0, 0, 4);
        // random phase
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(1, 7)),
                $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 60) == 0, $urandom_range(1, 8));
        end
        cyc(3'b000, 1, 0, 0, 3);
        @(posedge CLK);
        #3;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/or3_wake_filter.md
Name: or3_wake_filter

Overview:
- Downstream consumer of a 3-input OR wake function.
- Synchronizes three asynchronous request lines and debounces their OR.
- Raises a sticky wake flag Z, plus a source mask, until software/PMU acknowledges.
- Sits between raw pad/peripheral wake requests and the power-management controller.

Parameters:
SYNC_STAGES, 2, synchronizer depth per input (legal 2..4)
DEB_CYCLES, 4, consecutive qualified samples required before wake (legal 1..255)

Ports:
CLK  input  1  clock, rising-edge
RST  input  1  synchronous reset, active-high
A1   input  1  asynchronous wake request 1
A2   input  1  asynchronous wake request 2
A3   input  1  asynchronous wake request 3
EN   input  1  synchronous qualify enable; 0 masks all requests
ACK  input  1  synchronous acknowledge, level-sampled
Z    output 1  registered wake flag
SRC  output 3  registered source mask {A3,A2,A1}
VDD  inout  1  power, present only under USE_POWER_PINS
VSS  inout  1  ground, present only under USE_POWER_PINS

Behaviour:
- Interface (already decided): one clock CLK; RST is synchronous and active-high.
- Reset:
  - RST sampled high at an edge clears all synchronizer flops, the counter (cnt=0), state=IDLE, Z=0 and SRC=000 at that edge.
  - RST has priority over ACK, EN and inputs, including mid-FILTER and mid-ASSERT.
- Synchronizer:
  - Each Ai passes through SYNC_STAGES flops; outputs s[2:0].
  - Sync flops are unaffected by EN.
- Qualified request: any = EN & (s1|s2|s3).
- Counter: cnt width clog2(DEB_CYCLES+1). It saturates at DEB_CYCLES and never wraps.
- FSM, registered outputs:
  - IDLE (Z=0, SRC=000):
    - any=1 and DEB_CYCLES=1 -> ASSERT.
    - any=1 otherwise -> FILTER with cnt=1.
  - FILTER (Z=0):
    - any=0 -> IDLE, cnt=0 (glitch rejected).
    - else cnt+1; when cnt+1==DEB_CYCLES -> ASSERT.
  - Entering ASSERT: Z=1 and SRC=s at the same edge.
  - ASSERT (Z=1):
    - SRC |= s each cycle (later sources accumulate).
    - ACK=1 -> RELEASE; Z=0 and SRC=000 at that edge.
    - EN=0 does not drop Z; a pending wake is never lost.
  - RELEASE (Z=0):
    - Stays until any=0 at one sample, then -> IDLE.
    - This prevents re-triggering from the same held level.
- Latency:
  - Ai is high and stable from edge 0.
  - s visible after edge SYNC_STAGES-1.
  - Z rises at edge SYNC_STAGES+DEB_CYCLES-1.
  - Z falls at the edge ACK is sampled.
- ACK sampled in IDLE, FILTER or RELEASE is ignored.
- Simultaneous events:
  - ACK and a new source in ASSERT: ACK wins, SRC clears.
  - The new source needs a fresh release plus qualification.

Test Plan (SYNC_STAGES=2, DEB_CYCLES=4):
1. RST high 2 cycles with A2=1 -> Z=0, SRC=000 throughout; after RST low, Z=1 at the 5th edge after release.
2. A2 high for 3 cycles, then low -> Z never asserts; FSM returns to IDLE; cnt=0.
3. A1 held high from edge 0 -> Z=1, SRC=001 after edge 5; A3 rises at edge 6 -> SRC=101 after edge 8; ACK at edge 10 -> Z=0, SRC=000.
   - A1 still high -> no re-assert.
   - A1 low for 1+ sample, then high again -> new 4-sample qualification before Z=1.
4. A2 high while counting, low for exactly 1 synchronized cycle when cnt=3, then high -> count restarts from 1; Z asserts 4 samples after the return.
5. EN=0 with A3 high 10 cycles -> Z=0; EN=1 -> Z=1 exactly 4 edges later. EN=0 while Z=1 -> Z stays 1 until ACK.
6. RST asserted in FILTER (cnt=2) and separately in ASSERT with ACK=1 -> state IDLE, Z=0, SRC=000 at that edge; no wake resumes without requalification.
